ysyx_25060170_commit_trace: RTL and testbench
=============================================

# ysyx_25060170_commit_trace

Synthesizable consumer for the core's retirement stream. It accepts one retired-instruction record (pc, inst) per cycle from the LSU/WB commit point, buffers records in a small FIFO, and serves them to a debug/trace reader over a valid/ready port. It also detects the ebreak trap, stops accepting records, and reports trap completion once all buffered records have drained. It sits beside the core top and replaces simulator-only commit reporting in synthesized builds.

## Interface
**Parameters**
- DEPTH, 8: FIFO entries; must be a power of two, ≥2.
- AW, $clog2(DEPTH): pointer width (derived; do not override).

**Ports**
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- commit_valid  in  1  one instruction retires this cycle.
- commit_pc  in  32  pc of the retiring instruction.
- commit_inst  in  32  encoding of the retiring instruction.
- rd_valid  out  1  head record available.
- rd_ready  in  1  reader accepts the head record.
- rd_pc  out  32  head record pc.
- rd_inst  out  32  head record inst.
- level  out  AW+1  number of buffered records.
- drop_cnt  out  16  records lost to overflow; saturating.
- halt  out  1  ebreak has retired; sticky.
- halt_pc  out  32  pc of the ebreak.
- trap_done  out  1  halt is set and the FIFO is empty; sticky.

## Operation
- **Reset** clears all outputs to 0, clears both pointers, and sets the state to RUN.
- **States**
  - RUN: records are captured normally.
  - DRAIN: captures stop; the reader drains the FIFO.
  - DONE: terminal; only a reset leaves this state.
- **Transitions**
  - RUN→DRAIN: commit_valid and commit_inst == 32'h0010_0073 (EBREAK).
  - DRAIN→DONE: level == 0.
- **Write**
  - Only in RUN with commit_valid.
  - Accepted if level < DEPTH, or if a pop occurs in the same cycle (rd_valid & rd_ready).
  - Otherwise the record is dropped and drop_cnt increments, saturating at 16'hFFFF.
- **Ebreak record**
  - Captured like any other record, if there is space.
  - halt and halt_pc are set even when the ebreak record itself is dropped.
- Commits arriving in DRAIN or DONE are ignored and are not counted in drop_cnt.
- **Read**
  - rd_valid = (level != 0).
  - Pop on rd_valid & rd_ready.
  - rd_pc and rd_inst are stable while rd_valid is high and rd_ready is low.
- **Pointers** are AW bits and wrap modulo DEPTH. level is the write count minus the read count, held AW+1 bits wide.

## Timing
- **Write-to-read latency:** 1 cycle. A record written at edge N is visible on rd_* after edge N. There is no same-cycle bypass when the FIFO is empty.
- **Push and pop in the same cycle:** level is unchanged. This holds at full and at every other level.
- **halt timing:** halt and halt_pc assert at the clock edge that samples the ebreak commit. The state becomes DRAIN at the same edge.
- **trap_done timing:** trap_done asserts at the edge following the first cycle in DRAIN with level == 0. Example: ebreak written into an empty FIFO at edge N; popped at edge N+1; trap_done at edge N+2.
- **Reset mid-operation:** asynchronous reset discards the buffered records and clears halt and drop_cnt immediately.
- **Output timing:** all outputs are registered or derived only from registers. There is no combinational path from commit_* to rd_*.

## Structure
**Shared package** (ysyx_25060170_pkg). It holds:
- the EBREAK encoding constant;
- the state enum (RUN, DRAIN, DONE);
- the active-low reset level constant.

**Sub-module** ysyx_25060170_sync_fifo, parameterized on width and DEPTH. It provides:
- storage and pointers;
- level;
- push/pop with simultaneous-operation handling.

**Top module** holds the halt FSM, halt_pc register, drop counter, and accept logic.

## Test plan
- **Basic order:** 3 commits (pc 0x8000_0000/04/08) with rd_ready=1. Expect three pops in order, each one cycle after its commit; level peaks at 1.
- **Overflow (DEPTH=8):**
  - Stimulus: 10 commits with rd_ready=0.
  - Expect: level=8, drop_cnt=2, head pc = first pc.
  - Then assert rd_ready with commits idle. Expect eight pops, then rd_valid=0.
- **Simultaneous push and pop at full:** FIFO full, rd_ready=1, commit_valid=1. Expect the record accepted, level stays 8, drop_cnt unchanged.
- **Ebreak with backlog:**
  - Stimulus: commits pc 0x10, 0x14, then ebreak at 0x18, then 0x1C; rd_ready=0.
  - Expect: halt=1 and halt_pc=0x18 after the ebreak edge; 0x1C ignored; level=3.
  - Then drain with rd_ready=1. Expect trap_done=1 one cycle after level reaches 0.
- **Ebreak into full FIFO:** expect halt=1, halt_pc set, drop_cnt+1, and trap_done only after all 8 entries pop.
- **Reset mid-drain:** assert rst=0 during DRAIN with level=3. Expect immediately halt=0, level=0, rd_valid=0, drop_cnt=0, trap_done=0.

Source files
------------

// File: rtl/ysyx_25060170_pkg.sv
// rtl/ysyx_25060170_pkg.sv - shared constants and types for the commit trace block
package ysyx_25060170_pkg;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam logic        RST_ACTIVE  = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } trace_state_e;

endpackage

// File: rtl/ysyx_25060170_sync_fifo.sv
// rtl/ysyx_25060170_sync_fifo.sv - registered-output synchronous FIFO with push/pop in one cycle
module ysyx_25060170_sync_fifo
    import ysyx_25060170_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    assign do_push = push_i & (~full_o | do_pop);

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_25060170_commit_trace.sv
// rtl/ysyx_25060170_commit_trace.sv - buffers retired (pc, inst) records for a trace reader and tracks the ebreak halt
module ysyx_25060170_commit_trace
    import ysyx_25060170_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          commit_valid,
    input  logic [31:0]   commit_pc,
    input  logic [31:0]   commit_inst,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_inst,
    output logic [AW:0]   level,
    output logic [15:0]   drop_cnt,
    output logic          halt,
    output logic [31:0]   halt_pc,
    output logic          trap_done
);

    trace_state_e state_q;
    logic [15:0]  drop_q;
    logic         halt_q;
    logic [31:0]  halt_pc_q;
    logic         trap_done_q;

    logic         fifo_full;
    logic         fifo_empty;
    logic [63:0]  fifo_rdata;
    logic         pop;
    logic         wr_req;
    logic         accept;
    logic         drop;

    assign rd_valid = ~fifo_empty;
    assign pop      = rd_valid & rd_ready;
    assign wr_req   = (state_q == ST_RUN) & commit_valid;
    assign accept   = wr_req & (~fifo_full | pop);
    assign drop     = wr_req & ~accept;

    ysyx_25060170_sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (pop),
        .wdata_i ({commit_pc, commit_inst}),
        .rdata_o (fifo_rdata),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rd_pc     = fifo_rdata[63:32];
    assign rd_inst   = fifo_rdata[31:0];
    assign drop_cnt  = drop_q;
    assign halt      = halt_q;
    assign halt_pc   = halt_pc_q;
    assign trap_done = trap_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q     <= ST_RUN;
            drop_q      <= '0;
            halt_q      <= 1'b0;
            halt_pc_q   <= '0;
            trap_done_q <= 1'b0;
        end else begin
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
            case (state_q)
                ST_RUN: begin
                    // Halt is recorded whether or not the ebreak record found space.
                    if (commit_valid && (commit_inst == EBREAK_INST)) begin
                        state_q   <= ST_DRAIN;
                        halt_q    <= 1'b1;
                        halt_pc_q <= commit_pc;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_q     <= ST_DONE;
                        trap_done_q <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_DONE;
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_commit_trace.sv
// tb/tb_ysyx_25060170_commit_trace.sv - randomized and directed bench against a queue-based reference model
module tb_ysyx_25060170_commit_trace;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [31:0] commit_inst = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [3:0]  level;
    logic [15:0] drop_cnt;
    logic        halt;
    logic [31:0] halt_pc;
    logic        trap_done;

    ysyx_25060170_commit_trace #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_pc        (rd_pc),
        .rd_inst      (rd_inst),
        .level        (level),
        .drop_cnt     (drop_cnt),
        .halt         (halt),
        .halt_pc      (halt_pc),
        .trap_done    (trap_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } rec_t;

    rec_t        m_q[$];
    int          m_drops;
    bit          m_halt;
    logic [31:0] m_halt_pc;
    bit          m_done;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_drops   = 0;
        m_halt    = 0;
        m_halt_pc = '0;
        m_done    = 0;
    endtask

    task automatic check_all(input string tag, input bit check_head_zero);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_q.size() != 0));
        chk({tag, ".level"}, 32'(level), 32'(m_q.size()));
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
        chk({tag, ".halt"}, 32'(halt), 32'(m_halt));
        chk({tag, ".halt_pc"}, halt_pc, m_halt_pc);
        chk({tag, ".trap_done"}, 32'(trap_done), 32'(m_done));
        if (m_q.size() != 0) begin
            chk({tag, ".rd_pc"}, rd_pc, m_q[0].pc);
            chk({tag, ".rd_inst"}, rd_inst, m_q[0].inst);
        end else if (check_head_zero) begin
            chk({tag, ".rd_pc0"}, rd_pc, 32'h0);
            chk({tag, ".rd_inst0"}, rd_inst, 32'h0);
        end
    endtask

    // One clock: apply inputs, advance the model by the behavioural rules, compare after the edge.
    task automatic step(input string tag, input bit cv, input logic [31:0] pc,
                        input logic [31:0] inst, input bit rdy);
        bit   pop;
        bit   draining;
        rec_t r;
        commit_valid = cv;
        commit_pc    = pc;
        commit_inst  = inst;
        rd_ready     = rdy;
        pop      = (m_q.size() != 0) && rdy;
        draining = m_halt && !m_done;
        r.pc     = pc;
        r.inst   = inst;
        @(posedge clk);
        #1;
        if (draining && m_q.size() == 0) m_done = 1;
        if (pop) void'(m_q.pop_front());
        if (!m_halt && cv) begin
            if (m_q.size() < DEPTH) m_q.push_back(r);
            else if (m_drops < 65535) m_drops++;
            if (inst == EBREAK) begin
                m_halt    = 1;
                m_halt_pc = pc;
            end
        end
        check_all(tag, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag, 1'b1);
        commit_valid = 1'b0;
        rd_ready     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all({tag, ".rel"}, 1'b1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        v = $urandom;
        if (v == EBREAK) v = v ^ 32'h1;
        return v;
    endfunction

    initial begin
        model_reset();
        #2;
        check_all("reset", 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 3; i++)
            step("basic", 1'b1, 32'h8000_0000 + 32'(4 * i), rand_inst(), 1'b1);
        for (int i = 0; i < 2; i++) step("basic_idle", 1'b0, '0, '0, 1'b1);

        for (int i = 0; i < 10; i++)
            step("ovf", 1'b1, 32'h100 + 32'(4 * i), rand_inst(), 1'b0);
        chk("ovf.level8", 32'(level), 32'd8);
        chk("ovf.drop2", 32'(drop_cnt), 32'd2);
        chk("ovf.head", rd_pc, 32'h100);
        step("pushpop_full", 1'b1, 32'h200, rand_inst(), 1'b1);
        chk("pushpop.level8", 32'(level), 32'd8);
        for (int i = 0; i < 10; i++) step("ovf_drain", 1'b0, '0, '0, 1'b1);

        for (int i = 0; i < 300; i++)
            step("rand", ($urandom_range(0, 3) != 0), $urandom, rand_inst(),
                 ($urandom_range(0, 2) == 0));
        for (int i = 0; i < 10; i++) step("rand_drain", 1'b0, '0, '0, 1'b1);

        do_reset("rst1");
        step("ebk", 1'b1, 32'h10, rand_inst(), 1'b0);
        step("ebk", 1'b1, 32'h14, rand_inst(), 1'b0);
        step("ebk", 1'b1, 32'h18, EBREAK, 1'b0);
        step("ebk", 1'b1, 32'h1C, rand_inst(), 1'b0);
        chk("ebk.halt_pc", halt_pc, 32'h18);
        chk("ebk.level3", 32'(level), 32'd3);
        for (int i = 0; i < 6; i++) step("ebk_drain", 1'b1, 32'h40, rand_inst(), 1'b1);
        chk("ebk.done", 32'(trap_done), 32'd1);

        do_reset("rst2");
        for (int i = 0; i < 8; i++)
            step("full_fill", 1'b1, 32'h300 + 32'(4 * i), rand_inst(), 1'b0);
        step("full_ebk", 1'b1, 32'h400, EBREAK, 1'b0);
        chk("full_ebk.drop1", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 10; i++) step("full_drain", 1'b0, '0, '0, 1'b1);

        do_reset("rst3");
        step("mid", 1'b1, 32'h10, rand_inst(), 1'b0);
        step("mid", 1'b1, 32'h14, rand_inst(), 1'b0);
        step("mid", 1'b1, 32'h18, EBREAK, 1'b0);
        chk("mid.level3", 32'(level), 32'd3);
        #3;
        do_reset("rst_mid");
        step("post_rst", 1'b1, 32'h500, rand_inst(), 1'b1);
        step("post_rst", 1'b0, '0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
